lfsr_rng_param: RTL and testbench

Parametrised Fibonacci LFSR random-number generator, the next generation of the team's 16-bit fixed-tap generator. It supports configurable width, tap mask and output field, and advances 1 to 2^STEPS_W−1 steps per request. It accepts a runtime seed load and signals completion with a one-cycle `done` pulse. It sits between game/control FSMs that request random values and the datapath that consumes `rng_out` / `rng_out_narrow`.

---
 rtl/lfsr_rng_param.sv | 91 +++++++++
 tb/tb_lfsr_rng_param.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_param.sv
// Parametrised Fibonacci XNOR LFSR generator: multi-step requests, seed load, one-cycle done pulse.
// Optional `LFSR_LOCKUP_GUARD_EN: steers the all-ones lock-up state back to RESET_SEED.
module lfsr_rng_param #(
  parameter int unsigned       WIDTH      = 16,
  parameter logic [WIDTH-1:0]  TAPS       = 16'hD008,
  parameter logic [WIDTH-1:0]  RESET_SEED = 16'd5,
  parameter int unsigned       OUT_BITS   = 4,
  parameter int unsigned       STEPS_W    = 4
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               en_rng,
  input  logic [STEPS_W-1:0] steps,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   rng_out,
  output logic [WIDTH-1:0]   rng_out_narrow
);

  localparam logic [WIDTH-1:0] NARROW_MASK = {WIDTH{1'b1}} >> (WIDTH - OUT_BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_n;
  logic [STEPS_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0]   rng_n, shifted, next_val, seed_val;
  logic               fb;

  always_comb begin
    fb      = ~^(rng_out & TAPS);
    shifted = {rng_out[WIDTH-2:0], fb};
`ifdef LFSR_LOCKUP_GUARD_EN
    // All-ones never leaves itself under XNOR feedback, so recover to the reset seed.
    next_val = (&rng_out) ? RESET_SEED : shifted;
    seed_val = (&seed)    ? RESET_SEED : seed;
`else
    next_val = shifted;
    seed_val = seed;
`endif
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rng_n   = rng_out;
    case (state)
      IDLE: begin
        if (seed_load) begin
          rng_n = seed_val;
        end else if (en_rng) begin
          cnt_n   = (steps == '0) ? STEPS_W'(1) : steps;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        rng_n = next_val;
        cnt_n = cnt - STEPS_W'(1);
        if (cnt == STEPS_W'(1)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rng_out <= RESET_SEED;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rng_out <= rng_n;
      busy    <= (state_n == SHIFT);
      done    <= (state_n == DONE);
    end
  end

  assign rng_out_narrow = rng_out & NARROW_MASK;

endmodule

// File: tb/tb_lfsr_rng_param.sv
// Scoreboard bench for lfsr_rng_param: default 16-bit instance plus an 8-bit full-period instance.
module tb_lfsr_rng_param;

  logic        clock = 1'b0;
  logic        rst_a, en_a, seed_load_a;
  logic [3:0]  steps_a;
  logic [15:0] seed_a;
  logic        busy_a, done_a;
  logic [15:0] rng_a, narrow_a;

  logic        rst_b, en_b, seed_load_b;
  logic [3:0]  steps_b;
  logic [7:0]  seed_b;
  logic        busy_b, done_b;
  logic [7:0]  rng_b, narrow_b;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned done_count_a = 0;
  logic [15:0] exp_q_a[$];
  logic [7:0]  exp_q_b[$];
  logic [15:0] exp_a;
  logic [7:0]  exp_b;

  always #5 clock = ~clock;

  lfsr_rng_param dut_a (
    .clock(clock), .rst(rst_a), .en_rng(en_a), .steps(steps_a),
    .seed_load(seed_load_a), .seed(seed_a), .busy(busy_a), .done(done_a),
    .rng_out(rng_a), .rng_out_narrow(narrow_a)
  );

  lfsr_rng_param #(
    .WIDTH(8), .TAPS(8'hB8), .RESET_SEED(8'h01), .OUT_BITS(4), .STEPS_W(4)
  ) dut_b (
    .clock(clock), .rst(rst_b), .en_rng(en_b), .steps(steps_b),
    .seed_load(seed_load_b), .seed(seed_b), .busy(busy_b), .done(done_b),
    .rng_out(rng_b), .rng_out_narrow(narrow_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done_a === 1'b1) begin
      done_count_a++;
      vectors++;
      if (exp_q_a.size() == 0) begin
        miscompares++;
        $display("FAIL done_a_unexpected: pulse with rng_out %h, required no pulse", rng_a);
      end else begin
        exp_a = exp_q_a.pop_front();
        if (rng_a !== exp_a) begin
          miscompares++;
          $display("FAIL rng_a_at_done: got %h, required %h", rng_a, exp_a);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (done_b === 1'b1) begin
      vectors++;
      if (exp_q_b.size() == 0) begin
        miscompares++;
        $display("FAIL done_b_unexpected: pulse with rng_out %h, required no pulse", rng_b);
      end else begin
        exp_b = exp_q_b.pop_front();
        if (rng_b !== exp_b) begin
          miscompares++;
          $display("FAIL rng_b_at_done: got %h, required %h", rng_b, exp_b);
        end
      end
    end
  end

  task automatic reset_a();
    rst_a = 1'b1;
    repeat (2) @(negedge clock);
    rst_a = 1'b0;
  endtask

  // Called at a negedge in IDLE; returns at a negedge after DONE has cleared.
  task automatic request_a(input logic [3:0] st, input logic [15:0] expv,
                           input int unsigned k, input bit mid_load);
    int unsigned busy_cycles = 0;
    int unsigned n = 0;
    en_a    = 1'b1;
    steps_a = st;
    exp_q_a.push_back(expv);
    @(negedge clock);
    en_a = 1'b0;
    seed_a = 16'h1234;
    while (n < 40 && done_a !== 1'b1) begin
      seed_load_a = mid_load && (n == 0);
      if (busy_a === 1'b1) busy_cycles++;
      @(negedge clock);
      n++;
    end
    seed_load_a = 1'b0;
    check("done_seen_a", {31'd0, done_a}, 32'd1);
    check("busy_cycles_a", busy_cycles, k);
    check("busy_low_at_done_a", {31'd0, busy_a}, 32'd0);
    @(negedge clock);
  endtask

  task automatic request_b(input logic [7:0] expv);
    int unsigned n = 0;
    en_b    = 1'b1;
    steps_b = 4'd1;
    exp_q_b.push_back(expv);
    @(negedge clock);
    en_b = 1'b0;
    while (n < 20 && done_b !== 1'b1) begin
      @(negedge clock);
      n++;
    end
    if (done_b !== 1'b1) check("done_seen_b", {31'd0, done_b}, 32'd1);
    @(negedge clock);
  endtask

  logic [7:0]  model_b;
  bit          seen_b[256];
  int unsigned distinct_b;
  int unsigned c0;

  initial begin
    rst_a = 1'b0; en_a = 1'b0; seed_load_a = 1'b0; steps_a = '0; seed_a = '0;
    rst_b = 1'b1; en_b = 1'b0; seed_load_b = 1'b0; steps_b = '0; seed_b = '0;

    // Reset state and single step
    reset_a();
    check("reset_rng_a", rng_a, 32'h0005);
    check("reset_narrow_a", narrow_a, 32'h0005);
    check("reset_busy_a", {31'd0, busy_a}, 32'd0);
    check("reset_done_a", {31'd0, done_a}, 32'd0);
    request_a(4'd1, 16'h000B, 1, 1'b0);

    // Three steps from reset: 000B, 0016, 002D
    reset_a();
    request_a(4'd3, 16'h002D, 3, 1'b0);
    check("narrow_after_3", narrow_a, 32'h000D);

    // steps=0 behaves as 1, then seed_load beats en_rng
    reset_a();
    request_a(4'd0, 16'h000B, 1, 1'b0);
    seed_a = 16'h1234; seed_load_a = 1'b1; en_a = 1'b1; steps_a = 4'd2;
    @(negedge clock);
    seed_load_a = 1'b0; en_a = 1'b0;
    check("seed_priority_rng", rng_a, 32'h1234);
    for (int i = 0; i < 4; i++) begin
      check("seed_priority_busy", {31'd0, busy_a}, 32'd0);
      @(negedge clock);
    end
    check("seed_priority_hold", rng_a, 32'h1234);

    // Seed load during SHIFT is ignored
    reset_a();
    request_a(4'd3, 16'h002D, 3, 1'b1);

    // Reset on the second of five shifts
    reset_a();
    en_a = 1'b1; steps_a = 4'd5;
    @(negedge clock);
    en_a = 1'b0;
    @(negedge clock);
    check("shift1_before_rst", rng_a, 32'h000B);
    rst_a = 1'b1;
    @(negedge clock);
    rst_a = 1'b0;
    check("midrst_rng", rng_a, 32'h0005);
    check("midrst_busy", {31'd0, busy_a}, 32'd0);
    check("midrst_done", {31'd0, done_a}, 32'd0);
    repeat (8) @(negedge clock);
    check("midrst_rng_hold", rng_a, 32'h0005);

    // Lock-up seed
    reset_a();
    seed_a = 16'hFFFF; seed_load_a = 1'b1;
    @(negedge clock);
    seed_load_a = 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
    check("lockup_seed_guard", rng_a, 32'h0005);
    request_a(4'd4, 16'h005A, 4, 1'b0);
`else
    check("lockup_seed_plain", rng_a, 32'hFFFF);
    request_a(4'd4, 16'hFFFF, 4, 1'b0);
    check("lockup_stays", rng_a, 32'hFFFF);
`endif

    // Held en_rng: requests sampled at E0 and E3 within six edges
    reset_a();
    c0 = done_count_a;
    exp_q_a.push_back(16'h000B);
    exp_q_a.push_back(16'h0016);
    en_a = 1'b1; steps_a = 4'd1;
    repeat (6) @(negedge clock);
    en_a = 1'b0;
    repeat (3) @(negedge clock);
    check("backtoback_dones", done_count_a - c0, 32'd2);
    check("backtoback_rng", rng_a, 32'h0016);

    // 8-bit instance: full period of 255 single-step requests
    repeat (2) @(negedge clock);
    rst_b = 1'b0;
    check("reset_rng_b", rng_b, 32'h01);
    model_b    = 8'h01;
    distinct_b = 0;
    for (int i = 0; i < 256; i++) seen_b[i] = 1'b0;
    for (int i = 0; i < 255; i++) begin
      model_b = {model_b[6:0], ~^(model_b & 8'hB8)};
      request_b(model_b);
      if (!seen_b[rng_b]) distinct_b++;
      seen_b[rng_b] = 1'b1;
    end
    check("period_distinct_b", distinct_b, 32'd255);
    check("period_no_ff_b", {31'd0, seen_b[255]}, 32'd0);
    check("period_return_b", rng_b, 32'h01);
    check("narrow_b", narrow_b, 32'h01);

    check("pending_a", exp_q_a.size(), 32'd0);
    check("pending_b", exp_q_b.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
